regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 103 ++++++++++
 tb/tb_regfile_mp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NRP combinational read ports,
// optional write-to-read forwarding and a background sweep that clears every register.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [XLEN-1:0]   wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [XLEN-1:0]   wd1,
  input  logic [NRP*AW-1:0] ra,
  output logic [NRP*XLEN-1:0] rd,
  input  logic              clr_req,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [AW-1:0]   rd_addr [NRP];

  assign busy = (state_q == CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep starts at 1 since register 0 is already hardwired to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
    endcase
  end

  // Port 1 is applied last so it wins an address collision.
  always_comb begin
    for (int i = 0; i < NREG; i++) rf_d[i] = rf_q[i];
    if (busy) begin
      rf_d[cnt_q] = '0;
    end else begin
      if (we0) rf_d[wa0] = wd0;
      if (we1) rf_d[wa1] = wd1;
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  for (genvar k = 0; k < NRP; k++) begin : g_raddr
    assign rd_addr[k] = ra[k*AW +: AW];
  end

  always_comb begin
    rd = '0;
    for (int k = 0; k < NRP; k++) begin
      if (reset_n && !busy && (rd_addr[k] != '0)) begin
        rd[k*XLEN +: XLEN] = rf_q[rd_addr[k]];
        if (BYPASS != 0) begin
          if (we0 && (wa0 == rd_addr[k])) rd[k*XLEN +: XLEN] = wd0;
          if (we1 && (wa1 == rd_addr[k])) rd[k*XLEN +: XLEN] = wd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance and a 64-bit/16-reg/3-port/no-bypass
// instance, both compared every cycle against array-based models.
module tb_regfile_mp;
  localparam int XA = 32, NA = 32, PA = 2, AWA = 5;
  localparam int XB = 64, NB = 16, PB = 3, AWB = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic            a_we0, a_we1, a_clr, a_busy;
  logic [AWA-1:0]  a_wa0, a_wa1;
  logic [XA-1:0]   a_wd0, a_wd1;
  logic [PA*AWA-1:0] a_ra;
  logic [PA*XA-1:0]  a_rd;

  logic            b_we0, b_we1, b_clr, b_busy;
  logic [AWB-1:0]  b_wa0, b_wa1;
  logic [XB-1:0]   b_wd0, b_wd1;
  logic [PB*AWB-1:0] b_ra;
  logic [PB*XB-1:0]  b_rd;

  regfile_mp u_a (
    .clk(clk), .reset_n(reset_n),
    .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0),
    .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
    .ra(a_ra), .rd(a_rd), .clr_req(a_clr), .busy(a_busy)
  );

  regfile_mp #(.XLEN(XB), .NREG(NB), .NRP(PB), .BYPASS(0)) u_b (
    .clk(clk), .reset_n(reset_n),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0),
    .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .ra(b_ra), .rd(b_rd), .clr_req(b_clr), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Models: a sweep is treated as an instant wipe plus a busy window of NREG-1 cycles,
  // which is indistinguishable from outside since reads are forced to 0 meanwhile.
  logic [XA-1:0] ma [NA];
  logic [XB-1:0] mb [NB];
  int a_left = 0;
  int b_left = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NA; i++) ma[i] = '0;
      for (int i = 0; i < NB; i++) mb[i] = '0;
      a_left = 0;
      b_left = 0;
    end else begin
      if (a_left > 0) a_left--;
      else begin
        if (a_we0 && a_wa0 != 0) ma[a_wa0] = a_wd0;
        if (a_we1 && a_wa1 != 0) ma[a_wa1] = a_wd1;
        if (a_clr) begin
          for (int i = 0; i < NA; i++) ma[i] = '0;
          a_left = NA - 1;
        end
      end
      if (b_left > 0) b_left--;
      else begin
        if (b_we0 && b_wa0 != 0) mb[b_wa0] = b_wd0;
        if (b_we1 && b_wa1 != 0) mb[b_wa1] = b_wd1;
        if (b_clr) begin
          for (int i = 0; i < NB; i++) mb[i] = '0;
          b_left = NB - 1;
        end
      end
    end
  end

  function automatic logic [XA-1:0] exp_a(input logic [AWA-1:0] ad);
    if (!reset_n || a_left > 0 || ad == 0) return '0;
    if (a_we1 && a_wa1 == ad) return a_wd1;
    if (a_we0 && a_wa0 == ad) return a_wd0;
    return ma[ad];
  endfunction

  function automatic logic [XB-1:0] exp_b(input logic [AWB-1:0] ad);
    if (!reset_n || b_left > 0 || ad == 0) return '0;
    return mb[ad];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < PA; k++)
      chk($sformatf("a_rd%0d", k), 64'(a_rd[k*XA +: XA]), 64'(exp_a(a_ra[k*AWA +: AWA])));
    for (int k = 0; k < PB; k++)
      chk($sformatf("b_rd%0d", k), b_rd[k*XB +: XB], exp_b(b_ra[k*AWB +: AWB]));
    chk("a_busy", 64'(a_busy), 64'(reset_n && a_left > 0));
    chk("b_busy", 64'(b_busy), 64'(reset_n && b_left > 0));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_we0 = 0; a_we1 = 0; a_clr = 0; a_wa0 = '0; a_wa1 = '0; a_wd0 = '0; a_wd1 = '0; a_ra = '0;
    b_we0 = 0; b_we1 = 0; b_clr = 0; b_wa0 = '0; b_wa1 = '0; b_wd0 = '0; b_wd1 = '0; b_ra = '0;
  endtask

  int bc;
  logic [XB-1:0] newv;

  initial begin
    idle_inputs();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    cyc(); cyc();
    chk("rst_rd_a", 64'(a_rd), 64'(0));
    chk("rst_rd_b", b_rd[63:0], 64'(0));
    chk("rst_busy", 64'(a_busy), 64'(0));

    // Release and write on the very first edge.
    reset_n = 1'b1;
    a_we0 = 1; a_wa0 = 5; a_wd0 = 32'hDEADBEEF;
    cyc();
    a_we0 = 0; a_ra = {5'd5, 5'd5};
    #1;
    chk("x5_p0", 64'(a_rd[31:0]), 64'hDEADBEEF);
    chk("x5_p1", 64'(a_rd[63:32]), 64'hDEADBEEF);

    // Collision: port 1 wins, visible through bypass in the same cycle.
    a_we0 = 1; a_wa0 = 7; a_wd0 = 32'h11;
    a_we1 = 1; a_wa1 = 7; a_wd1 = 32'h22;
    a_ra = {5'd5, 5'd7};
    #1;
    chk("x7_byp", 64'(a_rd[31:0]), 64'h22);
    chk("x5_keep", 64'(a_rd[63:32]), 64'hDEADBEEF);
    cyc();
    a_we0 = 0; a_we1 = 0;
    #1;
    chk("x7_after", 64'(a_rd[31:0]), 64'h22);

    // Writes to x0 never become visible.
    a_we0 = 1; a_wa0 = 0; a_wd0 = 32'hFFFFFFFF; a_ra = '0;
    #1;
    chk("x0_same", 64'(a_rd), 64'(0));
    cyc();
    a_we0 = 0;
    #1;
    chk("x0_next", 64'(a_rd), 64'(0));
    cyc();
    chk("x0_later", 64'(a_rd), 64'(0));

    // No-bypass instance: old data same cycle, new data next cycle on all ports.
    b_we0 = 1; b_wa0 = 15; b_wd0 = 64'h1111;
    cyc();
    b_wd0 = 64'h0123456789ABCDEF; b_ra = {4'd15, 4'd15, 4'd15};
    #1;
    for (int k = 0; k < PB; k++) chk("r15_old", b_rd[k*XB +: XB], 64'h1111);
    cyc();
    b_we0 = 0;
    #1;
    for (int k = 0; k < PB; k++) chk("r15_new", b_rd[k*XB +: XB], 64'h0123456789ABCDEF);

    // Randomized traffic on both instances.
    for (int n = 0; n < 800; n++) begin
      cyc();
      a_we0 = 1'($urandom); a_we1 = 1'($urandom);
      a_wa0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a_wa1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a_wd0 = $urandom; a_wd1 = $urandom;
      a_ra = PA*AWA'($urandom);
      a_clr = ($urandom_range(0, 59) == 0);
      b_we0 = 1'($urandom); b_we1 = 1'($urandom);
      b_wa0 = 4'($urandom); b_wa1 = ($urandom_range(0, 1) != 0) ? b_wa0 : 4'($urandom);
      b_wd0 = {$urandom, $urandom}; b_wd1 = {$urandom, $urandom};
      b_ra = PB*AWB'($urandom);
      b_clr = ($urandom_range(0, 79) == 0);
    end
    idle_inputs();
    bc = 0;
    while ((a_busy || b_busy) && bc < 40) begin bc++; cyc(); end
    chk("drain", 64'(a_busy | b_busy), 64'(0));

    // Fill x1..x31, then sweep with writes and repeated clr_req during busy.
    for (int i = 1; i < NA; i += 2) begin
      a_we0 = 1; a_wa0 = 5'(i); a_wd0 = 32'hA5000000 | i;
      a_we1 = (i + 1 < NA); a_wa1 = 5'(i + 1); a_wd1 = 32'h5A000000 | (i + 1);
      cyc();
    end
    a_we0 = 0; a_we1 = 0;
    a_ra = {5'd31, 5'd1};
    #1;
    chk("fill_x1", 64'(a_rd[31:0]), 64'hA5000001);
    chk("fill_x31", 64'(a_rd[63:32]), 64'hA500001F);
    a_clr = 1;
    cyc();
    bc = 0;
    while (a_busy === 1'b1 && bc < 40) begin
      a_clr = (bc < 3);
      a_we0 = 1; a_wa0 = 5'($urandom_range(1, 31)); a_wd0 = $urandom | 1;
      a_we1 = 1; a_wa1 = 5'($urandom_range(1, 31)); a_wd1 = $urandom | 1;
      a_ra = PA*AWA'($urandom);
      #1;
      chk("clr_rd", 64'(a_rd), 64'(0));
      bc++;
      cyc();
    end
    a_clr = 0; a_we0 = 0; a_we1 = 0;
    chk("busy_len", 64'(bc), 64'(31));
    for (int i = 0; i < NA; i += 2) begin
      a_ra = {5'(i + 1), 5'(i)};
      #1;
      chk("post_clr", 64'(a_rd), 64'(0));
      cyc();
    end

    // Reset ten cycles into a sweep.
    a_we0 = 1; a_wa0 = 9; a_wd0 = 32'h99;
    cyc();
    a_we0 = 0; a_clr = 1;
    cyc();
    a_clr = 0;
    repeat (10) cyc();
    chk("mid_busy", 64'(a_busy), 64'(1));
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy_now", 64'(a_busy), 64'(0));
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    chk("idle_after", 64'(a_busy), 64'(0));
    for (int i = 0; i < NA; i += 2) begin
      a_ra = {5'(i + 1), 5'(i)};
      #1;
      chk("post_rst", 64'(a_rd), 64'(0));
      cyc();
    end
    chk("idle_still", 64'(a_busy), 64'(0));

    // One more write after the aborted sweep still lands.
    newv = 64'h0;
    a_we0 = 1; a_wa0 = 3; a_wd0 = 32'h3C3C3C3C;
    cyc();
    a_we0 = 0; a_ra = {5'd0, 5'd3};
    #1;
    newv[31:0] = a_rd[31:0];
    chk("x3_after", newv, 64'h3C3C3C3C);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
